arb_req_port: RTL and testbench
===============================

Name: arb_req_port

Overview:
- Requester-side client of the matrix arbiter. One instance per arbiter input.
- Buffers incoming flits in a small FIFO and raises `request` when it has a head flit and a downstream credit.
- On `grant`, pops the head flit, registers it onto the output, consumes a credit and reports `success` back to the arbiter's `success` input.
- Sits between an input port/VC buffer and one row of a crossbar switch-allocation stage.

Parameters:
- DATA_W, 32, flit width in bits.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- CREDITS, 4, downstream buffer slots; reset value and maximum of the credit counter, ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream flit valid.
- in_data  in  DATA_W  upstream flit.
- in_ready  out  1  FIFO can accept; a push occurs when in_valid & in_ready.
- request  out  1  request to arbiter.
- grant  in  1  grant from arbiter (combinational from request).
- success  out  1  grant accepted; drives arbiter success input.
- out_valid  out  1  flit sent this cycle.
- out_data  out  DATA_W  sent flit.
- credit_in  in  1  one downstream slot freed.
- credit_err  out  1  sticky credit overflow flag.

Behaviour:
- Reset: rst_n sampled on posedge clk, so it is synchronous active-low. It sets:
  - FIFO count=0 and read/write pointers=0;
  - credit counter=CREDITS;
  - out_valid=0, out_data=0, credit_err=0;
  - registered success=0.
  - Reset mid-operation discards all buffered flits; in-flight credits are not recovered.
- FIFO:
  - Count width is clog2(DEPTH+1).
  - in_ready = (count != DEPTH). No bypass: a flit pushed in cycle N is first visible at the head in cycle N+1.
  - Push and pop in the same cycle: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
  - When full, in_ready=0, so a simultaneous push with full is impossible.
- request = (count != 0) & (credit != 0). It is purely combinational from registers, so there is no path from grant to request.
- send = request & grant. A grant while request=0 is ignored: no pop, no credit change, no success.
- On send at edge N:
  - the head entry is popped;
  - out_data <= head;
  - out_valid <= 1 for exactly one cycle (N+1).
  - Latency from grant to out_valid is 1 cycle.
- Without send: out_valid <= 0 and out_data holds its last value.
- Back-to-back grants pop one flit per cycle while request stays high.
- Credit counter:
  - send alone: decrement.
  - credit_in alone: increment.
  - Both in the same cycle: unchanged.
  - credit=0 forces request=0.
  - credit_in with credit==CREDITS and no send: counter saturates at CREDITS and credit_err <= 1 (sticky until reset).
- success: see Optional Feature. It is never asserted without a matching send.

Optional Feature:
- Macro: ARB_LATE_SUCCESS_EN. Its default in both branches is pairing with an arbiter built with the matching multistage setting.
- Defined: success is registered. success <= send, so it asserts in cycle N+1, aligned with out_valid. Pair with multistage=2 arbiters.
- Undefined: success = send combinationally in cycle N. Pair with multistage=1 arbiters.

Test Plan:
- Reset then idle:
  - push 0xA5A5_0001 in cycle 1 → request=1 from cycle 2;
  - grant held high in cycle 3 → out_valid=1 and out_data=0xA5A5_0001 in cycle 4 only;
  - count returns to 0 and credit=3.
- Fill with 4 flits, no grant → in_ready=0 after the 4th push. A 5th in_valid is not accepted. Then grant for 4 consecutive cycles → 4 flits out in push order, one per cycle; in_ready=1 after the first pop.
- Credit starvation:
  - CREDITS=4, FIFO holds 6 pushes over time, grant tied 1 → exactly 4 sends, then request=0;
  - one credit_in pulse → exactly 1 further send.
- Simultaneous send and credit_in with credit=2 → credit stays 2. Simultaneous push and pop at count=2 → count stays 2, and data order is preserved across pointer wrap.
- Credit overflow: credit_in with credit=4 and no send → credit stays 4, credit_err=1 and stays 1 until rst_n=0.
- Success timing:
  - grant at cycle N with request=1 → success at cycle N (macro undefined) or at N+1 only (ARB_LATE_SUCCESS_EN);
  - grant with request=0 → success never asserts;
  - rst_n low mid-stream → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/arb_req_port.sv
// Requester-side arbiter client: FIFO-buffers flits, requests when a head flit and a credit exist, pops on grant.
// Latency: grant to out_valid/out_data 1 cycle; success same cycle (default) or +1 with ARB_LATE_SUCCESS_EN.
// Backpressure: in_ready drops when the FIFO is full; request drops when the FIFO is empty or credits are exhausted.
module arb_req_port #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              request,
    input  logic              grant,
    output logic              success,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              credit_in,
    output logic              credit_err
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CRD_W = $clog2(CREDITS + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CRD_W-1:0]  credit_q, credit_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              push;
    logic              send;

    // request depends only on registered state, so there is no loop through grant
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign request  = (count_q != '0) && (credit_q != '0);
    assign push     = in_valid && in_ready;
    assign send     = request && grant;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        credit_d    = credit_q;
        err_d       = err_q;
        out_valid_d = send;
        out_data_d  = out_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (send) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            out_data_d = mem_q[rd_ptr_q];
        end

        case ({push, send})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // a credit returned while already full is a protocol error; saturate and flag it
        case ({send, credit_in})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CRD_W'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            credit_q    <= CRD_W'(CREDITS);
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // storage needs no reset: entries are only read once count says they were written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign credit_err = err_q;

`ifdef ARB_LATE_SUCCESS_EN
    logic success_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            success_q <= 1'b0;
        end else begin
            success_q <= send;
        end
    end

    assign success = success_q;
`else
    assign success = send;
`endif

endmodule

// File: tb/tb_arb_req_port.sv
// Directed bench for arb_req_port: reset, FIFO fill/drain, credit starvation/overflow, success timing, mid-stream reset.
module tb_arb_req_port;
    localparam int DATA_W = 32;
`ifdef ARB_LATE_SUCCESS_EN
    localparam bit LATE = 1'b1;
`else
    localparam bit LATE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              request;
    logic              grant;
    logic              success;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              credit_in;
    logic              credit_err;

    int n_chk = 0;
    int n_err = 0;
    int nsent;

    always #5 clk = ~clk;

    arb_req_port #(.DATA_W(DATA_W), .DEPTH(4), .CREDITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .request    (request),
        .grant      (grant),
        .success    (success),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .credit_in  (credit_in),
        .credit_err (credit_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; grant = 1'b0; credit_in = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_request", request, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_credit_err", credit_err, 0);
        check("rst_success", success, 0);
        check("rst_credit", dut.credit_q, 4);
        check("rst_count", dut.count_q, 0);
        rst_n = 1'b1;
        tick();

        // single flit
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        check("t1_request", request, 1);
        grant = 1'b1;
        @(negedge clk);
        check("t1_success_n", success, LATE ? 0 : 1);
        tick();
        grant = 1'b0;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 32'hA5A5_0001);
        check("t1_success_n1", success, LATE ? 1 : 0);
        check("t1_count", dut.count_q, 0);
        check("t1_credit", dut.credit_q, 3);
        tick();
        check("t1_out_valid_drop", out_valid, 0);
        check("t1_out_data_hold", out_data, 32'hA5A5_0001);
        check("t1_success_drop", success, 0);

        // fill then drain in order
        credit_in = 1'b1; tick(); credit_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + i;
            tick();
        end
        check("fill_in_ready", in_ready, 0);
        in_data = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        check("fill_count_full", dut.count_q, 4);
        grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, 32'h100 + i);
            if (i == 0) check("drain_in_ready", in_ready, 1);
        end
        grant = 1'b0;
        tick();
        check("drain_request", request, 0);
        credit_in = 1'b1;
        repeat (4) tick();
        credit_in = 1'b0;
        check("refill_credit", dut.credit_q, 4);
        check("refill_err", credit_err, 0);

        // credit starvation with grant tied high
        nsent = 0;
        grant = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 6);
            in_data  = 32'h200 + i;
            tick();
            if (out_valid) begin
                check("starve_data", out_data, 32'h200 + nsent);
                nsent++;
            end
        end
        in_valid = 1'b0;
        check("starve_sends", nsent, 4);
        check("starve_request", request, 0);
        check("starve_count", dut.count_q, 2);
        credit_in = 1'b1; tick(); credit_in = 1'b0;
        nsent = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) nsent++;
        end
        check("starve_one_more", nsent, 1);
        check("starve_last_data", out_data, 32'h204);
        grant = 1'b0;

        // send and credit return together
        credit_in = 1'b1; repeat (2) tick();
        grant = 1'b1; tick();
        check("simul_credit", dut.credit_q, 2);
        check("simul_data", out_data, 32'h205);
        grant = 1'b0; credit_in = 1'b0;

        // push+pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h300 + i; tick();
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h302 + i; grant = 1'b1; credit_in = 1'b1;
            tick();
            check("wrap_valid", out_valid, 1);
            check("wrap_data", out_data, 32'h300 + i);
            check("wrap_count", dut.count_q, 2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wrap_tail", out_data, 32'h304 + i);
        end
        grant = 1'b0; credit_in = 1'b0;
        check("wrap_credit", dut.credit_q, 2);

        // credit overflow
        credit_in = 1'b1; repeat (2) tick();
        check("ovf_pre_err", credit_err, 0);
        check("ovf_pre_credit", dut.credit_q, 4);
        tick();
        credit_in = 1'b0;
        check("ovf_credit", dut.credit_q, 4);
        check("ovf_err", credit_err, 1);
        repeat (3) tick();
        check("ovf_sticky", credit_err, 1);

        // grant without request
        grant = 1'b1;
        @(negedge clk);
        check("norq_success_n", success, 0);
        tick();
        check("norq_success_n1", success, 0);
        check("norq_out_valid", out_valid, 0);
        grant = 1'b0;

        // reset mid-stream
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h400 + i; tick();
        end
        in_valid = 1'b0; grant = 1'b1;
        tick();
        check("mid_out_data", out_data, 32'h400);
        rst_n = 1'b0;
        tick();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_err", credit_err, 0);
        check("mrst_success", success, 0);
        check("mrst_request", request, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_credit", dut.credit_q, 4);
        grant = 1'b0; rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
